// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared encodings for the sequential calculator core.
//   op_e    : operation select as presented on i_op (add/sub/mul/div).
//   state_e : FSM state. The encoding is visible on o_state and drives the
//             display-select mux, so the values are fixed.
// -----------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE_A = 2'b00,
    WAIT_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per cycle.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load dividend/divisor and begin (ignored on abort)
//   i_abort        : drop any division in progress
//   i_dividend     : WIDTH-bit dividend
//   i_divisor      : WIDTH-bit divisor (caller screens out zero)
//   o_quotient     : quotient, valid in the cycle o_done is high
//   o_busy         : high for the WIDTH shift/subtract cycles
//   o_done         : high during the last shift/subtract cycle
// The final step is presented combinationally so the caller can capture the
// quotient on the same edge that retires the last step; this keeps the caller's
// EXEC phase at exactly one load cycle plus WIDTH step cycles.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 20
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff, rem_next, quo_next;
  logic             fits;

  // One restoring step. The partial remainder is always below the divisor, so
  // after a successful subtract the difference fits in WIDTH bits and the
  // modular WIDTH-bit subtraction is exact.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    diff    = shifted[WIDTH-1:0] - dvs_q;
    if (fits) begin
      rem_next = diff;
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (i_abort) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (i_start) begin
      rem_q  <= '0;
      quo_q  <= i_dividend;
      dvs_q  <= i_divisor;
      cnt_q  <= CW'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign o_quotient = quo_next;
  assign o_busy     = busy_q;
  assign o_done     = busy_q && (cnt_q == CW'(1));

endmodule

// File: rtl/calc_engine.sv
// -----------------------------------------------------------------------------
// calc_engine
// Sequential signed-magnitude calculator: operand A, operand B + op, result.
// The result can be chained back in as the next operand A.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_operand      : unsigned operand magnitude
//   i_enter        : one-cycle enter pulse
//   i_clear        : one-cycle synchronous clear (wins over i_enter)
//   i_op           : 00 add, 01 sub, 10 mul, 11 div (sampled with operand B)
//   o_result       : result magnitude (valid in SHOW)
//   o_sign         : result sign, 1 = negative
//   o_err          : overflow / divide by zero / division not built
//   o_busy         : high while in EXEC
//   o_done         : one-cycle pulse on entry to SHOW
//   o_state        : current state encoding (display select)
// Build option: define CALC_DIV_EN to instantiate seq_divider. Without it,
// op 11 completes in one EXEC cycle with the error flag set.
// -----------------------------------------------------------------------------
module calc_engine
  import calc_pkg::*;
#(
  parameter int          WIDTH   = 20,
  parameter int unsigned MAX_VAL = 999999
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_operand,
  input  logic             i_enter,
  input  logic             i_clear,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_sign,
  output logic             o_err,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state
);

  localparam int            PW       = 2 * WIDTH;
  localparam logic [PW-1:0] MAX_WIDE = PW'(MAX_VAL);

  state_e           state_q, state_next;
  op_e              op_q;
  logic             a_sign_q;
  logic [WIDTH-1:0] a_mag_q, b_mag_q, result_q;
  logic             sign_q, err_q, done_q;

  logic load_a, chain_a, load_b, show_load, err_ack;

  // Two extra bits: one for the sign, one so |A| + B cannot wrap.
  logic signed [WIDTH+1:0] a_val, b_val, sum;
  logic [WIDTH+1:0]        sum_mag;
  logic [PW-1:0]           raw_mag;
  logic                    raw_neg, raw_err;
  logic [WIDTH-1:0]        res_mag;
  logic                    res_neg, res_err;

`ifdef CALC_DIV_EN
  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_q;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (div_start),
    .i_abort    (i_clear),
    .i_dividend (a_mag_q),
    .i_divisor  (b_mag_q),
    .o_quotient (div_q),
    .o_busy     (div_busy),
    .o_done     (div_done)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE_A;
    else          state_q <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state_q;
    load_a     = 1'b0;
    chain_a    = 1'b0;
    load_b     = 1'b0;
    show_load  = 1'b0;
    err_ack    = 1'b0;
`ifdef CALC_DIV_EN
    div_start  = 1'b0;
`endif
    if (i_clear) begin
      state_next = IDLE_A;
    end else begin
      case (state_q)
        IDLE_A: if (i_enter) begin
          state_next = WAIT_B;
          load_a     = 1'b1;
        end
        WAIT_B: if (i_enter) begin
          state_next = EXEC;
          load_b     = 1'b1;
        end
        EXEC: begin
`ifdef CALC_DIV_EN
          if (op_q != OP_DIV) begin
            state_next = SHOW;
            show_load  = 1'b1;
          end else if (!div_busy) begin
            // First EXEC cycle of a divide: screen zero, otherwise load.
            if (b_mag_q == '0) begin
              state_next = SHOW;
              show_load  = 1'b1;
            end else begin
              div_start = 1'b1;
            end
          end else if (div_done) begin
            state_next = SHOW;
            show_load  = 1'b1;
          end
`else
          state_next = SHOW;
          show_load  = 1'b1;
`endif
        end
        SHOW: if (i_enter) begin
          if (err_q) begin
            state_next = IDLE_A;
            err_ack    = 1'b1;
          end else begin
            state_next = WAIT_B;
            chain_a    = 1'b1;
          end
        end
        default: state_next = IDLE_A;
      endcase
    end
  end

  // Result datapath: raw signed-magnitude result, then the overflow screen.
  always_comb begin
    a_val = $signed({2'b00, a_mag_q});
    if (a_sign_q) a_val = -a_val;
    b_val   = $signed({2'b00, b_mag_q});
    sum     = (op_q == OP_SUB) ? (a_val - b_val) : (a_val + b_val);
    sum_mag = $unsigned(sum[WIDTH+1] ? -sum : sum);

    raw_mag = '0;
    raw_neg = 1'b0;
    raw_err = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        raw_mag = PW'(sum_mag);
        raw_neg = sum[WIDTH+1];  // a negative sum is never zero
      end
      OP_MUL: begin
        raw_mag = {{WIDTH{1'b0}}, a_mag_q} * {{WIDTH{1'b0}}, b_mag_q};
        raw_neg = a_sign_q && (raw_mag != '0);
      end
      OP_DIV: begin
`ifdef CALC_DIV_EN
        raw_mag = PW'(div_q);
        raw_neg = a_sign_q && (div_q != '0);
        raw_err = (b_mag_q == '0);
`else
        raw_err = 1'b1;
`endif
      end
    endcase

    if (raw_err || (raw_mag > MAX_WIDE)) begin
      res_mag = '0;
      res_neg = 1'b0;
      res_err = 1'b1;
    end else begin
      res_mag = raw_mag[WIDTH-1:0];
      res_neg = raw_neg;
      res_err = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q     <= OP_ADD;
      a_sign_q <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (i_clear) begin
      a_sign_q <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= show_load;
      if (load_a) begin
        a_sign_q <= 1'b0;
        a_mag_q  <= i_operand;
      end else if (chain_a) begin
        a_sign_q <= sign_q;
        a_mag_q  <= result_q;
      end
      if (load_b) begin
        b_mag_q <= i_operand;
        op_q    <= op_e'(i_op);
      end
      if (show_load) begin
        result_q <= res_mag;
        sign_q   <= res_neg;
        err_q    <= res_err;
      end else if (err_ack) begin
        err_q <= 1'b0;
      end
    end
  end

  assign o_result = result_q;
  assign o_sign   = sign_q;
  assign o_err    = err_q;
  assign o_busy   = (state_q == EXEC);
  assign o_done   = done_q;
  assign o_state  = state_q;

endmodule
